// File: rtl/i2c_master_arbiter_if.sv
// i2c_master_arbiter_if: requester-side handshakes plus i2c_master_v2 command/status/FIFO ports
interface i2c_master_arbiter_if #(parameter int N_REQ = 2);
  logic [N_REQ-1:0] req;
  logic [32*N_REQ-1:0] req_cmd;
  logic [N_REQ-1:0] wd_valid;
  logic [8*N_REQ-1:0] wd_data;
  logic [N_REQ-1:0] wd_ready;
  logic [N_REQ-1:0] rd_valid;
  logic [7:0] rd_data;
  logic [N_REQ-1:0] rd_ready;
  logic [N_REQ-1:0] done;
  logic done_err;
  logic [10:0] done_code;
  logic m_i2c_send;
  logic [31:0] m_command;
  logic [31:0] m_status;
  logic m_w_en;
  logic [7:0] m_w_data;
  logic m_r_en;
  logic [7:0] m_r_data;
  modport slave (
    input req, req_cmd, wd_valid, wd_data, rd_ready, m_status, m_r_data,
    output wd_ready, rd_valid, rd_data, done, done_err, done_code, m_i2c_send, m_command, m_w_en, m_w_data, m_r_en
  );
  modport master (
    output req, req_cmd, wd_valid, wd_data, rd_ready, m_status, m_r_data,
    input wd_ready, rd_valid, rd_data, done, done_err, done_code, m_i2c_send, m_command, m_w_en, m_w_data, m_r_en
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one i2c master (clk, rst, bus.slave: requester req/wd/rd/done side and master m_* side)
module i2c_master_arbiter #(
  parameter int N_REQ = 2,
  parameter int W_DATA_DEPTH = 8,
  parameter int R_DATA_DEPTH = 8,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input logic clk,
  input logic rst,
  i2c_master_arbiter_if.slave bus
);
  localparam int GW = $clog2(N_REQ);
  typedef enum logic [3:0] {IDLE, CHECK, LOAD, SEND, ARM, WAIT, POP, CAP, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [GW-1:0] g, g_n, rr, rr_n, pick;
  logic [31:0] cmd, cmd_n;
  logic [14:0] pushed, pushed_n, len;
  logic [15:0] wdog, wdog_n;
  logic [10:0] code, code_n;
  logic [7:0] rdata, rdata_n;
  logic [N_REQ-1:0] gsel;
  logic any, legal, rw, stale, loading, fire;
  assign len = cmd[14:0];
  assign rw = cmd[15];
  assign gsel = N_REQ'(1) << g;
  assign legal = len != '0 && int'(len) <= (rw ? R_DATA_DEPTH : W_DATA_DEPTH);
  assign stale = !rw && !bus.m_status[16];
  assign loading = state == LOAD && pushed < len;
  assign fire = loading && bus.wd_valid[g];
  always_comb begin
    any = 1'b0;
    pick = '0;
    for (int i = 0; i < N_REQ; i++)
      if (!any && bus.req[(int'(rr) + i) % N_REQ]) begin
        any = 1'b1;
        pick = GW'((int'(rr) + i) % N_REQ);
      end
  end
  always_comb begin
    state_n = state;
    g_n = g;
    rr_n = rr;
    cmd_n = cmd;
    pushed_n = pushed;
    wdog_n = wdog;
    code_n = code;
    rdata_n = rdata;
    case (state)
      IDLE: if (any) begin
        g_n = pick;
        cmd_n = bus.req_cmd[32*int'(pick) +: 32];
        pushed_n = '0;
        state_n = CHECK;
      end
      CHECK: begin
        code_n = !legal ? 11'h7FF : stale ? 11'h7FD : 11'h000;
        state_n = (!legal || stale) ? DONE : rw ? SEND : LOAD;
      end
      LOAD: if (fire) begin
        pushed_n = pushed + 15'd1;
        state_n = pushed_n == len ? SEND : LOAD;
      end
      SEND: state_n = ARM;
      ARM: begin
        wdog_n = '0;
        state_n = WAIT;
      end
      WAIT: if (!bus.m_status[31]) begin
        code_n = bus.m_status[30:20];
        state_n = (rw && !bus.m_status[18]) ? POP : DONE;
      end else begin
        wdog_n = wdog + 16'd1;
        if (TIMEOUT != '0 && wdog_n == TIMEOUT) begin
          code_n = 11'h7FE;
          state_n = DONE;
        end
      end
      POP: state_n = CAP;
      CAP: begin
        rdata_n = bus.m_r_data;
        state_n = HOLD;
      end
      HOLD: if (bus.rd_ready[g]) state_n = bus.m_status[18] ? DONE : POP;
      DONE: begin
        rr_n = int'(g) == N_REQ - 1 ? '0 : g + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      g <= '0;
      rr <= '0;
      cmd <= '0;
      pushed <= '0;
      wdog <= '0;
      code <= '0;
      rdata <= '0;
    end else begin
      state <= state_n;
      g <= g_n;
      rr <= rr_n;
      cmd <= cmd_n;
      pushed <= pushed_n;
      wdog <= wdog_n;
      code <= code_n;
      rdata <= rdata_n;
    end
  assign bus.wd_ready = loading ? gsel : '0;
  assign bus.m_w_en = fire;
  assign bus.m_w_data = fire ? bus.wd_data[8*int'(g) +: 8] : '0;
  assign bus.rd_valid = state == HOLD ? gsel : '0;
  assign bus.rd_data = rdata;
  assign bus.done = state == DONE ? gsel : '0;
  assign bus.done_code = state == DONE ? code : '0;
  assign bus.done_err = state == DONE && code != '0;
  assign bus.m_i2c_send = state == SEND;
  assign bus.m_command = cmd;
  assign bus.m_r_en = state == POP;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: directed checks of i2c_master_arbiter against a small i2c master model
module tb_i2c_master_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  i2c_master_arbiter_if #(.N_REQ(2)) bus ();
  i2c_master_arbiter #(.N_REQ(2), .W_DATA_DEPTH(8), .R_DATA_DEPTH(8), .TIMEOUT(16'd20)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0, n_err = 0;
  logic busy, hold = 1'b0, stale = 1'b0;
  int bcnt, rcnt, rp, wcnt, lat = 0, rn_cfg = 0;
  logic [10:0] fail_cfg = '0;
  logic [7:0] rdat [0:7];
  logic [31:0] mcmd;
  assign bus.m_status = {busy, fail_cfg, 1'b0, rcnt == 0, 1'b0, wcnt == 0 && !stale, 8'(rcnt), 8'h00};
  always @(posedge clk or posedge rst)
    if (rst) begin
      busy <= 1'b0;
      bcnt <= 0;
      rcnt <= 0;
      rp <= 0;
      wcnt <= 0;
      mcmd <= '0;
      bus.m_r_data <= '0;
    end else begin
      if (bus.m_w_en) wcnt <= wcnt + 1;
      if (bus.m_i2c_send) begin
        busy <= 1'b1;
        bcnt <= lat;
        mcmd <= bus.m_command;
      end else if (busy && !hold) begin
        if (bcnt == 0) begin
          busy <= 1'b0;
          wcnt <= 0;
          if (mcmd[15]) begin
            rcnt <= rn_cfg;
            rp <= 0;
          end
        end else bcnt <= bcnt - 1;
      end
      if (bus.m_r_en) begin
        bus.m_r_data <= rdat[rp & 7];
        rp <= rp + 1;
        rcnt <= rcnt - 1;
      end
    end
  int n_send = 0, n_wen = 0, n_ren = 0, n_dual = 0, cyc = 0, t_send = 0, t_done = 0;
  logic [7:0] wlog [$];
  int dlog [$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.m_i2c_send) begin
      n_send <= n_send + 1;
      t_send <= cyc;
    end
    if (bus.m_w_en) begin
      n_wen <= n_wen + 1;
      wlog.push_back(bus.m_w_data);
    end
    if (bus.m_r_en) n_ren <= n_ren + 1;
    if ($countones(bus.done) > 1) n_dual <= n_dual + 1;
    if (bus.done != '0) begin
      t_done <= cyc;
      dlog.push_back(bus.done[1] ? 1 : 0);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  logic [7:0] wb [0:7];
  logic [7:0] rgot [0:7];
  int rgn;
  task automatic txn(input int idx, input logic [31:0] c, input int nw, input int maxc, output logic [10:0] code, output logic err, output int cyc_n);
    int k;
    logic waiting;
    logic got;
    k = 0;
    waiting = 1'b0;
    got = 1'b0;
    rgn = 0;
    code = 11'h555;
    err = 1'bx;
    cyc_n = 0;
    bus.req_cmd[32*idx +: 32] = c;
    bus.wd_data[8*idx +: 8] = wb[0];
    bus.wd_valid[idx] = nw > 0;
    bus.req[idx] = 1'b1;
    while (!got && cyc_n < maxc) begin
      @(negedge clk);
      cyc_n++;
      if (bus.wd_valid[idx] && bus.wd_ready[idx]) k++;
      if (bus.rd_valid[idx]) begin
        if (bus.rd_ready[idx]) begin
          if (rgn < 8) rgot[rgn] = bus.rd_data;
          rgn++;
          waiting = 1'b0;
        end else waiting = 1'b1;
      end
      if (bus.done != '0) begin
        got = 1'b1;
        chk("done_onehot", 32'(bus.done), 32'(1) << idx);
        code = bus.done_code;
        err = bus.done_err;
      end
      @(posedge clk);
      #1;
      bus.wd_valid[idx] = k < nw;
      bus.wd_data[8*idx +: 8] = wb[k < 8 ? k : 7];
      bus.rd_ready[idx] = waiting && bus.rd_valid[idx];
    end
    bus.req[idx] = 1'b0;
    bus.wd_valid[idx] = 1'b0;
    bus.rd_ready[idx] = 1'b0;
    chk("done_seen", 32'(got), 1);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end
  initial begin
    logic [10:0] code;
    logic err;
    int cn, s0, w0, r0, d0;
    bus.req = '0;
    bus.req_cmd = '0;
    bus.wd_valid = '0;
    bus.wd_data = '0;
    bus.rd_ready = '0;
    rdat[0] = 8'h11; rdat[1] = 8'h22; rdat[2] = 8'h33; rdat[3] = 8'h44;
    rdat[4] = 8'h55; rdat[5] = 8'h66; rdat[6] = 8'h77; rdat[7] = 8'h88;
    for (int i = 0; i < 8; i++) wb[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({bus.wd_ready, bus.rd_valid, bus.done, bus.done_err, bus.m_i2c_send, bus.m_w_en, bus.m_r_en}), 0);
    chk("rst_data", 32'({bus.done_code, bus.m_w_data, bus.rd_data}), 0);
    chk("rst_command", bus.m_command, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    // write 2 bytes from requester 0, slave ACKs
    lat = 3; wb[0] = 8'hA5; wb[1] = 8'h3C;
    s0 = n_send; w0 = wlog.size();
    txn(0, 32'hA000_0002, 2, 100, code, err, cn);
    chk("wr_code", 32'(code), 0);
    chk("wr_err", 32'(err), 0);
    chk("wr_sends", n_send - s0, 1);
    chk("wr_wen", wlog.size() - w0, 2);
    chk("wr_byte0", 32'(wlog[w0]), 32'h0A5);
    chk("wr_byte1", 32'(wlog[w0+1]), 32'h03C);
    // read 3 bytes from requester 1
    lat = 2; rn_cfg = 3;
    s0 = n_send; r0 = n_ren;
    txn(1, 32'hA000_8003, 0, 100, code, err, cn);
    chk("rd_code", 32'(code), 0);
    chk("rd_count", rgn, 3);
    chk("rd_byte0", 32'(rgot[0]), 32'h11);
    chk("rd_byte1", 32'(rgot[1]), 32'h22);
    chk("rd_byte2", 32'(rgot[2]), 32'h33);
    chk("rd_ren", n_ren - r0, 3);
    chk("rd_sends", n_send - s0, 1);
    rn_cfg = 0;
    // illegal lengths
    s0 = n_send;
    txn(0, 32'hA000_0000, 0, 20, code, err, cn);
    chk("ill_w0_code", 32'(code), 32'h7FF);
    chk("ill_w0_err", 32'(err), 1);
    chk("ill_w0_lat", 32'(cn <= 3), 1);
    txn(0, 32'hA000_8009, 0, 20, code, err, cn);
    chk("ill_r9_code", 32'(code), 32'h7FF);
    chk("ill_r9_lat", 32'(cn <= 3), 1);
    chk("ill_sends", n_send - s0, 0);
    // address NACK on a 1-byte write from requester 1, immediate master completion
    lat = 0; fail_cfg = 11'h003; wb[0] = 8'h5A;
    txn(1, 32'hA000_0001, 1, 100, code, err, cn);
    chk("nack_code", 32'(code), 32'h003);
    chk("nack_err", 32'(err), 1);
    chk("nack_lat", cn, 7);
    fail_cfg = '0;
    // stale bytes in the master write FIFO
    stale = 1'b1; s0 = n_send; w0 = n_wen; wb[0] = 8'h77;
    txn(0, 32'hA000_0001, 1, 50, code, err, cn);
    chk("stale_code", 32'(code), 32'h7FD);
    chk("stale_noload", n_wen - w0, 0);
    chk("stale_nosend", n_send - s0, 0);
    stale = 1'b0;
    // master stuck busy trips the watchdog
    hold = 1'b1;
    txn(1, 32'hA000_8001, 0, 100, code, err, cn);
    chk("wdog_code", 32'(code), 32'h7FE);
    chk("wdog_err", 32'(err), 1);
    chk("wdog_cycles", t_done - t_send, 22);
    hold = 1'b0;
    repeat (10) @(negedge clk);
    // both requesters held: grants alternate
    lat = 1;
    bus.req_cmd = {32'hA000_0001, 32'hA000_0001};
    bus.wd_data = {8'h22, 8'h11};
    d0 = dlog.size(); w0 = wlog.size();
    bus.wd_valid = 2'b11;
    bus.req = 2'b11;
    for (int i = 0; i < 300 && dlog.size() < d0 + 4; i++) @(negedge clk);
    bus.req = '0;
    bus.wd_valid = '0;
    chk("rr_dones", dlog.size() - d0, 4);
    chk("rr_g0", dlog[d0], 0);
    chk("rr_g1", dlog[d0+1], 1);
    chk("rr_g2", dlog[d0+2], 0);
    chk("rr_g3", dlog[d0+3], 1);
    chk("rr_dual", n_dual, 0);
    chk("rr_wbytes", 32'({wlog[w0], wlog[w0+1], wlog[w0+2], wlog[w0+3]}), 32'h11221122);
    @(posedge clk); #1;
    // leave the pointer at 1, then abort requester 1 in LOAD with reset
    wb[0] = 8'h5A;
    txn(0, 32'hA000_0001, 1, 100, code, err, cn);
    chk("pre_code", 32'(code), 0);
    bus.req_cmd[63:32] = 32'hA000_0002;
    bus.req[1] = 1'b1;
    for (int i = 0; i < 20 && bus.wd_ready != 2'b10; i++) @(negedge clk);
    chk("abort_in_load", 32'(bus.wd_ready), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("abort_ctl", 32'({bus.wd_ready, bus.rd_valid, bus.done, bus.done_err, bus.m_i2c_send, bus.m_w_en, bus.m_r_en}), 0);
    chk("abort_cmd", bus.m_command, 0);
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    d0 = dlog.size();
    bus.req_cmd = {32'hA000_0001, 32'hA000_0001};
    bus.wd_valid = 2'b11;
    bus.req = 2'b11;
    for (int i = 0; i < 100 && dlog.size() < d0 + 1; i++) @(negedge clk);
    bus.req = '0;
    bus.wd_valid = '0;
    chk("post_rst_done", dlog.size() - d0, 1);
    chk("post_rst_grant0", dlog.size() > d0 ? dlog[d0] : -1, 0);
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Shares one i2c_master_v2 instance between N_REQ requesters.
- Grants one transaction at a time, round-robin, and fully sequences it: loads write bytes into the master's write FIFO, pulses i2c_send, waits for completion, drains read bytes back to the owner, then reports the fail code.
- Sits between the requester clients and the master's command/status/FIFO ports, on the same clock.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- W_DATA_DEPTH, 8, master write FIFO depth; also the maximum write length.
- R_DATA_DEPTH, 8, master read FIFO depth; also the maximum read length.
- TIMEOUT, 16'hFFFF, watchdog limit in cycles while waiting for the master to go idle; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, shared with the master.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester transaction request; level, held until done.
- req_cmd  in  32*N_REQ  per-requester command word in master format. [31:25] addr, [24:17] data addr, [16] data-addr-en, [15] rw, [14:0] len.
- wd_valid  in  N_REQ  per-requester write-byte valid.
- wd_data  in  8*N_REQ  per-requester write byte.
- wd_ready  out  N_REQ  write byte accepted (granted requester only).
- rd_valid  out  N_REQ  read byte valid (granted requester only).
- rd_data  out  8  read byte, shared bus.
- rd_ready  in  N_REQ  per-requester read-byte accept.
- done  out  N_REQ  one-cycle completion pulse to the owner.
- done_err  out  1  valid with done; 1 when done_code != 0.
- done_code  out  11  valid with done; master fail code or arbiter code.
- m_i2c_send  out  1  to master i2c_send.
- m_command  out  32  to master command.
- m_status  in  32  from master status.
- m_w_en  out  1  master write FIFO push.
- m_w_data  out  8  master write FIFO data.
- m_r_en  out  1  master read FIFO pop.
- m_r_data  in  8  master read FIFO data; valid one cycle after m_r_en.

Behaviour:
- Master status fields: [31] busy, [30:20] fail_code, [18] rbuf empty, [16] wbuf empty, [15:8] rbuf count.
- Reset: state IDLE, rr pointer 0, all outputs 0, m_command 0.
- Reset mid-transaction aborts immediately. No done is issued.
- Length rule: len = cmd[14:0], rw = cmd[15].
  - Write (rw=0) is legal for len 1..W_DATA_DEPTH.
  - Read (rw=1) is legal for len 1..R_DATA_DEPTH.
- States and transitions:
  - IDLE: when any req is high, grant the first requester at or after the rr pointer (wrapping) and latch its cmd. -> CHECK.
  - CHECK (1 cycle):
    - Illegal len -> DONE with code 11'h7FF.
    - Write with m_status[16]=0 (stale bytes in the write FIFO) -> DONE with code 11'h7FD.
    - Write otherwise -> LOAD.
    - Read -> SEND.
  - LOAD:
    - wd_ready[g] is high while pushed < len.
    - Each wd_valid[g]&wd_ready[g] cycle: m_w_en=1 and m_w_data=wd_data[g] in the same cycle (combinational pass-through); pushed++.
    - When pushed == len -> SEND.
  - SEND: m_i2c_send=1 for exactly one cycle; m_command = latched cmd, held stable through DONE. -> ARM.
  - ARM (1 cycle; the master reports busy here). -> WAIT.
  - WAIT: wait for m_status[31]=0.
    - Watchdog counts WAIT cycles; at count == TIMEOUT (TIMEOUT != 0) -> DONE with code 11'h7FE.
    - On idle, latch fail = m_status[30:20].
    - If rw=1 and m_status[18]=0 -> POP; else -> DONE with code = fail.
  - POP: m_r_en=1 for one cycle. -> CAP.
  - CAP: capture m_r_data into the rd_data register. -> HOLD.
  - HOLD: rd_valid[g]=1.
    - On rd_ready[g]: if m_status[18]=1 -> DONE, else -> POP.
    - Fewer than len bytes are legal (NACKed read).
  - DONE (1 cycle): done[g]=1, done_code, done_err. rr pointer = g+1 mod N_REQ. -> IDLE.
- Only the granted index g may see wd_ready, rd_valid or done. All other bits are 0.
- req[g] dropping mid-transaction is ignored; the transaction completes.
- Minimum cycles, req to done:
  - Illegal command: 3.
  - Write with 1 byte and immediate wd_valid: the master latency plus 6.

Test Plan:
- req[0], write addr 7'h50, len 2, bytes 8'hA5, 8'h3C, slave ACKs all -> two m_w_en pulses carrying A5 then 3C; one m_i2c_send; done[0]=1 with done_code 0.
- req[1], read len 3, slave returns 11, 22, 33 -> rd_valid[1] three times with 11, 22, 33, each held until rd_ready; then done[1]; m_r_en pulses = 3.
- req=2'b11 held continuously, all transactions legal -> grants alternate 0,1,0,1; done never asserts on both bits at once.
- req[0], write len 0; separately, read len R_DATA_DEPTH+1 -> done[0] within 3 cycles, done_code 11'h7FF, no m_i2c_send.
- Slave NACKs the address on a write -> done_code 11'h003, done_err=1.
- Master held busy, TIMEOUT=20 -> done_code 11'h7FE after 20 WAIT cycles.
- Assert rst during LOAD -> all outputs 0 asynchronously; after release, a new req is served with rr pointer 0.
